// File: rtl/edge_layer_mem_if.sv
// Bus between the edge-detection controller and its layer memory.
// The master side is the controller, the slave side is edge_layer_mem.
// The edge_cnt signal exists only when EDGE_CNT_EN is defined.
interface edge_layer_mem_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
);
   logic              busy;
   logic              cwr;
   logic [ADDR_W-1:0] caddr_wr;
   logic [DATA_W-1:0] cdata_wr;
   logic              crd;
   logic [ADDR_W-1:0] caddr_rd_1, caddr_rd_2, caddr_rd_3;
   logic [ADDR_W-1:0] caddr_rd_4, caddr_rd_5, caddr_rd_6;
   logic [ADDR_W-1:0] caddr_rd_7, caddr_rd_8, caddr_rd_9;
   logic [2:0]        csel;
   logic [DATA_W-1:0] cdata_rd_1, cdata_rd_2, cdata_rd_3;
   logic [DATA_W-1:0] cdata_rd_4, cdata_rd_5, cdata_rd_6;
   logic [DATA_W-1:0] cdata_rd_7, cdata_rd_8, cdata_rd_9;
   logic              dout_valid;
   logic              dout_ready;
   logic [ADDR_W-1:0] dout_addr;
   logic [DATA_W-1:0] dout_data;
   logic              done;
`ifdef EDGE_CNT_EN
   logic [12:0]       edge_cnt;
`endif

   modport master (
      output busy, cwr, caddr_wr, cdata_wr, crd, csel, dout_ready,
      output caddr_rd_1, caddr_rd_2, caddr_rd_3, caddr_rd_4, caddr_rd_5,
      output caddr_rd_6, caddr_rd_7, caddr_rd_8, caddr_rd_9,
      input  cdata_rd_1, cdata_rd_2, cdata_rd_3, cdata_rd_4, cdata_rd_5,
      input  cdata_rd_6, cdata_rd_7, cdata_rd_8, cdata_rd_9,
      input  dout_valid, dout_addr, dout_data, done
`ifdef EDGE_CNT_EN
      , input edge_cnt
`endif
   );

   modport slave (
      input  busy, cwr, caddr_wr, cdata_wr, crd, csel, dout_ready,
      input  caddr_rd_1, caddr_rd_2, caddr_rd_3, caddr_rd_4, caddr_rd_5,
      input  caddr_rd_6, caddr_rd_7, caddr_rd_8, caddr_rd_9,
      output cdata_rd_1, cdata_rd_2, cdata_rd_3, cdata_rd_4, cdata_rd_5,
      output cdata_rd_6, cdata_rd_7, cdata_rd_8, cdata_rd_9,
      output dout_valid, dout_addr, dout_data, done
`ifdef EDGE_CNT_EN
      , output edge_cnt
`endif
   );
endinterface

// File: rtl/edge_layer_mem.sv
// Layer memory for the edge-detection datapath: two 64x64x8 banks (L1, L2)
// with one write port and nine registered read ports, plus a valid/ready
// dump of the whole L2 bank once the controller drops busy.
// Optional macro EDGE_CNT_EN adds edge_cnt, the number of 0xFF pixels seen
// in the most recent dump.
module edge_layer_mem #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4096
) (
   input logic               clk,
   input logic               reset,
   edge_layer_mem_if.slave   bus
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] ARMED    = 2'd1;
   localparam logic [1:0] DUMP_RD  = 2'd2;
   localparam logic [1:0] DUMP_OUT = 2'd3;

   localparam logic [2:0] SEL_L1 = 3'b001;
   localparam logic [2:0] SEL_L2 = 3'b010;

   logic [DATA_W-1:0] l1Mem [DEPTH];
   logic [DATA_W-1:0] l2Mem [DEPTH];

   logic [ADDR_W-1:0] rdAddr   [9];
   logic [DATA_W-1:0] rdData_q [9];

   logic [1:0]        state_q, state_d;
   logic              busy_q;
   logic [ADDR_W-1:0] doutAddr_q, doutAddr_d;
   logic [DATA_W-1:0] doutData_q, doutData_d;
   logic              done_q, done_d;

   logic              dumping;
   logic              accept;
   logic              lastWord;
   logic              dumpStart;

   assign rdAddr[0] = bus.caddr_rd_1;
   assign rdAddr[1] = bus.caddr_rd_2;
   assign rdAddr[2] = bus.caddr_rd_3;
   assign rdAddr[3] = bus.caddr_rd_4;
   assign rdAddr[4] = bus.caddr_rd_5;
   assign rdAddr[5] = bus.caddr_rd_6;
   assign rdAddr[6] = bus.caddr_rd_7;
   assign rdAddr[7] = bus.caddr_rd_8;
   assign rdAddr[8] = bus.caddr_rd_9;

   assign bus.cdata_rd_1 = rdData_q[0];
   assign bus.cdata_rd_2 = rdData_q[1];
   assign bus.cdata_rd_3 = rdData_q[2];
   assign bus.cdata_rd_4 = rdData_q[3];
   assign bus.cdata_rd_5 = rdData_q[4];
   assign bus.cdata_rd_6 = rdData_q[5];
   assign bus.cdata_rd_7 = rdData_q[6];
   assign bus.cdata_rd_8 = rdData_q[7];
   assign bus.cdata_rd_9 = rdData_q[8];

   assign dumping   = (state_q == DUMP_RD) || (state_q == DUMP_OUT);
   assign accept    = (state_q == DUMP_OUT) && bus.dout_ready;
   assign lastWord  = (doutAddr_q == ADDR_W'(DEPTH - 1));
   assign dumpStart = (state_q == ARMED) && busy_q && !bus.busy;

   // dout_valid comes straight from the state so an async reset drops it at once
   assign bus.dout_valid = (state_q == DUMP_OUT);
   assign bus.dout_addr  = doutAddr_q;
   assign bus.dout_data  = doutData_q;
   assign bus.done       = done_q;

   // Bank write port; the banks have no reset and other csel codes drop the write
   always_ff @(posedge clk) begin
      if (bus.cwr) begin
         if (bus.csel == SEL_L1) begin
            l1Mem[bus.caddr_wr] <= bus.cdata_wr;
         end else if (bus.csel == SEL_L2) begin
            l2Mem[bus.caddr_wr] <= bus.cdata_wr;
         end
      end
   end

   // Nine registered read ports, frozen while the dump owns the memory
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 9; i++) begin
            rdData_q[i] <= '0;
         end
      end else if (bus.crd && !dumping) begin
         for (int i = 0; i < 9; i++) begin
            case (bus.csel)
               SEL_L1:  rdData_q[i] <= l1Mem[rdAddr[i]];
               SEL_L2:  rdData_q[i] <= l2Mem[rdAddr[i]];
               default: rdData_q[i] <= '0;
            endcase
         end
      end
   end

   // Dump sequencer: arm on busy, start on its falling edge, then fetch/present each L2 word
   always_comb begin
      state_d    = state_q;
      doutAddr_d = doutAddr_q;
      doutData_d = doutData_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.busy) begin
               state_d = ARMED;
            end
         end
         ARMED: begin
            if (dumpStart) begin
               state_d    = DUMP_RD;
               doutAddr_d = '0;
            end
         end
         DUMP_RD: begin
            doutData_d = l2Mem[doutAddr_q];
            state_d    = DUMP_OUT;
         end
         default: begin
            if (bus.dout_ready) begin
               if (lastWord) begin
                  state_d    = IDLE;
                  done_d     = 1'b1;
                  doutAddr_d = '0;
               end else begin
                  state_d    = DUMP_RD;
                  doutAddr_d = doutAddr_q + ADDR_W'(1);
               end
            end
         end
      endcase
   end

   // Sequencer state and the registered busy used for falling-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         doutAddr_q <= '0;
         doutData_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= bus.busy;
         doutAddr_q <= doutAddr_d;
         doutData_q <= doutData_d;
         done_q     <= done_d;
      end
   end

`ifdef EDGE_CNT_EN
   logic [12:0] edgeCnt_q;

   // Count saturated (edge) pixels among the words the sink accepts during a dump
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         edgeCnt_q <= '0;
      end else if (dumpStart) begin
         edgeCnt_q <= '0;
      end else if (accept && (doutData_q == {DATA_W{1'b1}})) begin
         edgeCnt_q <= edgeCnt_q + 13'd1;
      end
   end

   assign bus.edge_cnt = edgeCnt_q;
`endif

endmodule

// File: tb/tb_edge_layer_mem.sv
// Self-checking bench for edge_layer_mem: directed write/read/collision
// cases, randomized read/write traffic against a memory model, a full L2
// dump with backpressure, and a reset in the middle of a dump.
module tb_edge_layer_mem;

   logic clk = 1'b0;
   logic reset = 1'b0;

   edge_layer_mem_if bus ();

   edge_layer_mem dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [11:0] rAddr [9];
   logic [7:0]  rdOut [9];

   assign bus.caddr_rd_1 = rAddr[0];
   assign bus.caddr_rd_2 = rAddr[1];
   assign bus.caddr_rd_3 = rAddr[2];
   assign bus.caddr_rd_4 = rAddr[3];
   assign bus.caddr_rd_5 = rAddr[4];
   assign bus.caddr_rd_6 = rAddr[5];
   assign bus.caddr_rd_7 = rAddr[6];
   assign bus.caddr_rd_8 = rAddr[7];
   assign bus.caddr_rd_9 = rAddr[8];

   assign rdOut[0] = bus.cdata_rd_1;
   assign rdOut[1] = bus.cdata_rd_2;
   assign rdOut[2] = bus.cdata_rd_3;
   assign rdOut[3] = bus.cdata_rd_4;
   assign rdOut[4] = bus.cdata_rd_5;
   assign rdOut[5] = bus.cdata_rd_6;
   assign rdOut[6] = bus.cdata_rd_7;
   assign rdOut[7] = bus.cdata_rd_8;
   assign rdOut[8] = bus.cdata_rd_9;

   // Reference model: bank contents and what each read port should show
   logic [7:0] refL1 [4096];
   logic [7:0] refL2 [4096];
   logic [7:0] expRd [9];

   int checks = 0;
   int passes = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] modelRead(input logic [2:0] sel, input logic [11:0] a);
      if (sel == 3'b001) return refL1[a];
      if (sel == 3'b010) return refL2[a];
      return 8'h00;
   endfunction

   // One idle-state memory cycle: reads see the banks as they were before this cycle's write
   task automatic applyStimulus(input logic wr, input logic [2:0] sel, input logic [11:0] wa,
                                input logic [7:0] wd, input logic rd);
      bus.cwr      = wr;
      bus.csel     = sel;
      bus.caddr_wr = wa;
      bus.cdata_wr = wd;
      bus.crd      = rd;
      if (rd) begin
         for (int i = 0; i < 9; i++) expRd[i] = modelRead(sel, rAddr[i]);
      end
      if (wr && sel == 3'b001) refL1[wa] = wd;
      else if (wr && sel == 3'b010) refL2[wa] = wd;
      tick();
      bus.cwr = 1'b0;
      bus.crd = 1'b0;
   endtask

   task automatic preloadBanks();
      for (int a = 0; a < 4096; a++) applyStimulus(1'b1, 3'b001, 12'(a), 8'($urandom), 1'b0);
      for (int a = 0; a < 4096; a++) applyStimulus(1'b1, 3'b010, 12'(a), 8'($urandom), 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 9; i++) begin
         expRd[i] = 8'h00;
         checks++;
         if (rdOut[i] !== 8'h00) $display("[TB] FAIL reset_cdata_rd_%0d: got %h expected 00", i + 1, rdOut[i]);
         else passes++;
      end
      checks++;
      if (bus.dout_valid !== 1'b0) $display("[TB] FAIL reset_dout_valid: got %b expected 0", bus.dout_valid);
      else passes++;
      checks++;
      if (bus.dout_addr !== 12'h000) $display("[TB] FAIL reset_dout_addr: got %h expected 000", bus.dout_addr);
      else passes++;
      checks++;
      if (bus.dout_data !== 8'h00) $display("[TB] FAIL reset_dout_data: got %h expected 00", bus.dout_data);
      else passes++;
      checks++;
      if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done);
      else passes++;
`ifdef EDGE_CNT_EN
      checks++;
      if (bus.edge_cnt !== 13'd0) $display("[TB] FAIL reset_edge_cnt: got %0d expected 0", bus.edge_cnt);
      else passes++;
`endif
      reset = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      for (int i = 0; i < 9; i++) rAddr[i] = 12'($urandom);
      rAddr[4] = 12'h041;
      applyStimulus(1'b1, 3'b001, 12'h041, 8'h5A, 1'b0);
      applyStimulus(1'b0, 3'b001, 12'h000, 8'h00, 1'b1);
      checks++;
      if (rdOut[4] !== 8'h5A) $display("[TB] FAIL write_read_l1: got %h expected 5a", rdOut[4]);
      else passes++;
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (rdOut[i] !== expRd[i]) $display("[TB] FAIL write_read_port_%0d: got %h expected %h", i + 1, rdOut[i], expRd[i]);
         else passes++;
      end
      for (int i = 0; i < 9; i++) rAddr[i] = 12'($urandom);
      applyStimulus(1'b0, 3'b010, 12'h000, 8'h00, 1'b0);
      checks++;
      if (rdOut[4] !== 8'h5A) $display("[TB] FAIL crd0_hold: got %h expected 5a", rdOut[4]);
      else passes++;
   endtask

   task automatic test_bank_isolation();
      rAddr[4] = 12'h041;
      applyStimulus(1'b1, 3'b010, 12'h041, 8'hFF, 1'b0);
      applyStimulus(1'b0, 3'b001, 12'h000, 8'h00, 1'b1);
      checks++;
      if (rdOut[4] !== 8'h5A) $display("[TB] FAIL iso_read_l1: got %h expected 5a", rdOut[4]);
      else passes++;
      applyStimulus(1'b0, 3'b010, 12'h000, 8'h00, 1'b1);
      checks++;
      if (rdOut[4] !== 8'hFF) $display("[TB] FAIL iso_read_l2: got %h expected ff", rdOut[4]);
      else passes++;
      applyStimulus(1'b1, 3'b011, 12'h041, 8'h77, 1'b0);
      applyStimulus(1'b0, 3'b001, 12'h000, 8'h00, 1'b1);
      checks++;
      if (rdOut[4] !== 8'h5A) $display("[TB] FAIL iso_sel011_l1: got %h expected 5a", rdOut[4]);
      else passes++;
      applyStimulus(1'b0, 3'b010, 12'h000, 8'h00, 1'b1);
      checks++;
      if (rdOut[4] !== 8'hFF) $display("[TB] FAIL iso_sel011_l2: got %h expected ff", rdOut[4]);
      else passes++;
      applyStimulus(1'b0, 3'b100, 12'h000, 8'h00, 1'b1);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (rdOut[i] !== 8'h00) $display("[TB] FAIL iso_no_bank_port_%0d: got %h expected 00", i + 1, rdOut[i]);
         else passes++;
      end
   endtask

   task automatic test_collision();
      rAddr[4] = 12'h100;
      applyStimulus(1'b1, 3'b001, 12'h100, 8'h11, 1'b0);
      applyStimulus(1'b1, 3'b001, 12'h100, 8'h33, 1'b1);
      checks++;
      if (rdOut[4] !== 8'h11) $display("[TB] FAIL collision_old_data: got %h expected 11", rdOut[4]);
      else passes++;
      applyStimulus(1'b0, 3'b001, 12'h000, 8'h00, 1'b1);
      checks++;
      if (rdOut[4] !== 8'h33) $display("[TB] FAIL collision_new_data: got %h expected 33", rdOut[4]);
      else passes++;
   endtask

   task automatic test_random_rw();
      logic [2:0]  sel;
      logic [11:0] wa;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 9; i++) begin
            rAddr[i] = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom);
         end
         sel = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(1, 2));
         wa  = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom);
         applyStimulus(1'($urandom), sel, wa, 8'($urandom), ($urandom_range(0, 3) != 0));
         for (int i = 0; i < 9; i++) begin
            checks++;
            if (rdOut[i] !== expRd[i]) $display("[TB] FAIL random_rw_port_%0d iter %0d: got %h expected %h", i + 1, n, rdOut[i], expRd[i]);
            else passes++;
         end
      end
   endtask

   task automatic test_dump_backpressure();
      int idx = 0;
      int pat = 0;
      int cyc = 0;
      int lastAcceptCyc = -10;
      int expEdge = 0;
      logic sawDone = 1'b0;
      logic stalled = 1'b0;
      logic readyNow;
      logic [11:0] holdAddr = '0;
      logic [7:0]  holdData = '0;
      logic [3:0]  readyPat = 4'b1001;
      for (int a = 0; a < 4096; a++) applyStimulus(1'b1, 3'b010, 12'(a), 8'(a), 1'b0);
      for (int a = 0; a < 4096; a++) if (refL2[a] == 8'hFF) expEdge++;
      bus.csel       = 3'b001;
      bus.dout_ready = 1'b0;
      bus.busy       = 1'b1;
      tick();
      bus.busy = 1'b0;
      while (!sawDone && cyc < 20000) begin
         tick();
         cyc++;
         if (bus.done) begin
            sawDone = 1'b1;
            bus.crd = 1'b0;
            bus.dout_ready = 1'b0;
            checks++;
            if (idx !== 4096) $display("[TB] FAIL done_word_count: got %0d expected 4096", idx);
            else passes++;
            checks++;
            if (cyc !== lastAcceptCyc + 1) $display("[TB] FAIL done_timing: got cycle %0d expected %0d", cyc, lastAcceptCyc + 1);
            else passes++;
         end else if (bus.dout_valid) begin
            bus.crd = 1'b1;
            for (int i = 0; i < 9; i++) rAddr[i] = 12'($urandom);
            if (stalled) begin
               checks++;
               if (bus.dout_addr !== holdAddr || bus.dout_data !== holdData)
                  $display("[TB] FAIL stall_hold: got %h/%h expected %h/%h", bus.dout_addr, bus.dout_data, holdAddr, holdData);
               else passes++;
            end
            checks++;
            if (bus.dout_addr !== 12'(idx)) $display("[TB] FAIL dump_addr: got %h expected %h", bus.dout_addr, 12'(idx));
            else passes++;
            checks++;
            if (bus.dout_data !== refL2[12'(idx)]) $display("[TB] FAIL dump_data @%0d: got %h expected %h", idx, bus.dout_data, refL2[12'(idx)]);
            else passes++;
            readyNow       = readyPat[pat % 4];
            pat++;
            bus.dout_ready = readyNow;
            stalled        = !readyNow;
            holdAddr       = bus.dout_addr;
            holdData       = bus.dout_data;
            if (readyNow) begin
               idx++;
               lastAcceptCyc = cyc;
            end
         end else begin
            bus.dout_ready = 1'b0;
         end
      end
      checks++;
      if (!sawDone) $display("[TB] FAIL dump_timeout: got no done within %0d cycles, expected done", cyc);
      else passes++;
`ifdef EDGE_CNT_EN
      checks++;
      if (bus.edge_cnt !== 13'(expEdge)) $display("[TB] FAIL edge_cnt: got %0d expected %0d", bus.edge_cnt, expEdge);
      else passes++;
`endif
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.dout_valid !== 1'b0) $display("[TB] FAIL done_single_pulse: got done=%b valid=%b expected 0/0", bus.done, bus.dout_valid);
      else passes++;
`ifdef EDGE_CNT_EN
      checks++;
      if (bus.edge_cnt !== 13'(expEdge)) $display("[TB] FAIL edge_cnt_stable: got %0d expected %0d", bus.edge_cnt, expEdge);
      else passes++;
`endif
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (rdOut[i] !== expRd[i]) $display("[TB] FAIL dump_crd_ignored_port_%0d: got %h expected %h", i + 1, rdOut[i], expRd[i]);
         else passes++;
      end
   endtask

   task automatic test_reset_mid_dump();
      int cyc = 0;
      int doneCnt = 0;
      int badValid = 0;
      logic hit = 1'b0;
      logic gotWord = 1'b0;
      bus.dout_ready = 1'b1;
      bus.busy = 1'b1;
      tick();
      bus.busy = 1'b0;
      while (!hit && cyc < 3000) begin
         tick();
         cyc++;
         if (bus.done) doneCnt++;
         if (bus.dout_valid && bus.dout_addr == 12'h200) hit = 1'b1;
      end
      checks++;
      if (hit !== 1'b1) $display("[TB] FAIL reach_addr_200: got %b expected 1", hit);
      else passes++;
      reset = 1'b0;
      #1;
      checks++;
      if (bus.dout_valid !== 1'b0) $display("[TB] FAIL abort_valid_async: got %b expected 0", bus.dout_valid);
      else passes++;
      checks++;
      if (bus.dout_addr !== 12'h000) $display("[TB] FAIL abort_addr: got %h expected 000", bus.dout_addr);
      else passes++;
      for (int i = 0; i < 9; i++) expRd[i] = 8'h00;
      tick();
      tick();
      reset = 1'b1;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (bus.done) doneCnt++;
         if (bus.dout_valid) badValid++;
      end
      checks++;
      if (doneCnt !== 0) $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", doneCnt);
      else passes++;
      checks++;
      if (badValid !== 0) $display("[TB] FAIL abort_idle: got %0d valid cycles expected 0", badValid);
      else passes++;
      bus.busy = 1'b1;
      tick();
      bus.busy = 1'b0;
      cyc = 0;
      while (!gotWord && cyc < 10) begin
         tick();
         cyc++;
         if (bus.dout_valid) gotWord = 1'b1;
      end
      checks++;
      if (gotWord !== 1'b1) $display("[TB] FAIL restart_timeout: got no word expected valid");
      else passes++;
      checks++;
      if (bus.dout_addr !== 12'h000 || bus.dout_data !== refL2[0])
         $display("[TB] FAIL restart_first_word: got %h/%h expected 000/%h", bus.dout_addr, bus.dout_data, refL2[0]);
      else passes++;
      bus.dout_ready = 1'b0;
   endtask

   initial begin
      bus.busy       = 1'b0;
      bus.cwr        = 1'b0;
      bus.caddr_wr   = '0;
      bus.cdata_wr   = '0;
      bus.crd        = 1'b0;
      bus.csel       = 3'b000;
      bus.dout_ready = 1'b0;
      for (int i = 0; i < 9; i++) rAddr[i] = '0;
      test_reset();
      preloadBanks();
      test_write_read();
      test_bank_isolation();
      test_collision();
      test_random_rw();
      test_dump_backpressure();
      test_reset_mid_dump();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/edge_layer_mem.md
Name: edge_layer_mem

Overview:
- Layer-memory responder for the edge-detection datapath. It is the memory side of the controller's cwr/caddr_wr/cdata_wr/crd/caddr_rd_1..9/csel interface.
- Holds two 64x64x8 banks: Layer1 (L1) and Layer2 (L2). Serves one synchronous write and nine registered reads per cycle.
- After the controller drops busy, it streams the L2 bank out over a valid/ready port for capture or checking.

Parameters:
- ADDR_W, 12, pixel address width; address is {y[5:0], x[5:0]}.
- DATA_W, 8, pixel width.
- DEPTH, 4096, words per bank (must equal 2**ADDR_W).

Ports:
- clk  input  1  clock; everything is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- busy  input  1  controller busy flag, used to arm and trigger the dump.
- cwr  input  1  write enable.
- caddr_wr  input  ADDR_W  write address.
- cdata_wr  input  DATA_W  write data.
- crd  input  1  read enable for the nine read ports.
- caddr_rd_1..caddr_rd_9  input  ADDR_W each  3x3 window read addresses.
- csel  input  3  bank select: 001 = L1, 010 = L2, all other codes = none.
- cdata_rd_1..cdata_rd_9  output  DATA_W each  registered read data.
- dout_valid  output  1  dump word valid.
- dout_ready  input  1  dump sink ready.
- dout_addr  output  ADDR_W  address of the current dump word.
- dout_data  output  DATA_W  L2 pixel at dout_addr.
- done  output  1  one-cycle pulse after the last dump word is accepted.
- edge_cnt  output  13  count of 0xFF pixels (present only with EDGE_CNT_EN).

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE; all cdata_rd_n = 0; dout_valid = 0, dout_addr = 0, dout_data = 0, done = 0, edge_cnt = 0. Bank contents are not reset.
- Write:
  - cwr=1 with csel=001 writes cdata_wr to L1[caddr_wr]; with csel=010 writes to L2[caddr_wr].
  - Any other csel code: the write is dropped.
  - Memory updates at the clock edge.
- Read:
  - With crd=1 and FSM not in a dump state, each cdata_rd_n <= bank[caddr_rd_n] at the edge, so data is valid 1 cycle after the address.
  - Bank is L1 for csel=001 and L2 for csel=010. Any other csel loads 0.
  - crd=0: cdata_rd_n hold their values.
- Same-cycle read and write to the same address and bank: the read returns the old data (read-before-write).
- FSM states: IDLE, ARMED, DUMP_RD, DUMP_OUT.
  - IDLE -> ARMED when busy=1.
  - ARMED -> DUMP_RD on busy 1->0, detected with a registered busy_d (busy_d=1, busy=0). dout_addr <= 0.
  - DUMP_RD: registers L2[dout_addr] into dout_data, then goes to DUMP_OUT.
  - DUMP_OUT: dout_valid=1. On dout_ready=1:
    - If dout_addr==DEPTH-1: go to IDLE, done=1 for one cycle, dout_addr <= 0.
    - Otherwise: dout_addr+1 and go to DUMP_RD.
  - DUMP_OUT with dout_ready=0: dout_valid, dout_addr and dout_data are held stable.
- Throughput: minimum 2 cycles per word; a full dump of 4096 words takes at least 8192 cycles.
- During DUMP_RD/DUMP_OUT: crd is ignored and cdata_rd_n hold. cwr is still honoured, but the dump reads whatever the bank holds at its DUMP_RD cycle.
- busy rising during a dump is ignored. Re-arming happens only from IDLE.
- Reset asserted mid-dump aborts immediately: no done pulse, dout_valid drops asynchronously.
- Address arithmetic wraps modulo DEPTH. No out-of-range addresses exist.

Optional Feature:
- Macro: EDGE_CNT_EN.
- Defined:
  - edge_cnt is cleared on the ARMED->DUMP_RD transition.
  - It increments on each accepted dump word (DUMP_OUT and dout_ready) whose dout_data==8'hFF.
  - It is final and stable from the done pulse until the next dump starts.
- Not defined: the edge_cnt port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset/write/read: reset pulse -> all cdata_rd_n=0, dout_valid=0. Write L1[0x041]=0x5A (cwr=1, csel=001), then crd=1, csel=001, caddr_rd_5=0x041 -> cdata_rd_5=0x5A exactly 1 cycle later.
- Bank isolation: write L2[0x041]=0xFF (csel=010). Read with csel=001 -> 0x5A; with csel=010 -> 0xFF. A write with csel=011 to 0x041 -> both banks unchanged.
- Collision: cwr=1 to L1[0x100]=0x33 while crd=1 reads L1[0x100], which holds 0x11 -> cdata returns 0x11; the next read returns 0x33.
- Dump with backpressure: preload L2[i]=i[7:0], busy 0->1->0, dout_ready toggling 1,0,0,1 -> words in order 0..4095 with matching data and values stable while stalled. done pulses once after address 4095 is accepted. EDGE_CNT_EN -> edge_cnt=16.
- Reset mid-dump: reset=0 at dout_addr=0x200 -> dout_valid=0 immediately, no done pulse. After release the FSM is in IDLE, and a new busy cycle restarts the dump at address 0.
